c2c_link_arbiter: RTL
=====================

C2C_LINK_ARBITER -- requirements
Module: c2c_link_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of local requesters sharing the chip-to-chip master link.
REQ-002 Parameter DELAY_CYCLES, default 100000000: cycles notice is held before data is driven; legal range 1 to 2^27-1.
REQ-003 Parameter TIMEOUT_CYCLES, default 200000000: maximum cycles spent waiting for any ack edge; legal range 1 to 2^28-1.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req  input  N_REQ  per-requester level request; bit i is held high by requester i until done[i] or timeout_err.
REQ-007 req_data  input  3*N_REQ  packed payloads; requester i uses bits [3i+2:3i].
REQ-008 ack  input  1  acknowledge from the slave chip; asynchronous to this block's logic.
REQ-009 request2s  output  1  link request to the slave.
REQ-010 notice  output  1  high while the delay count runs.
REQ-011 data  output  3  link payload.
REQ-012 valid  output  1  payload qualifier.
REQ-013 grant  output  N_REQ  one-hot link owner; all zero when idle.
REQ-014 done  output  N_REQ  one-cycle pulse on the owner's bit when its transfer completes.
REQ-015 timeout_err  output  1  one-cycle pulse when a transfer is aborted.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 ack shall pass through a 2-flop synchronizer; every ack reference below means the synchronized value.
REQ-018 The state machine shall have four states: IDLE, REQ, WAIT, SEND; all outputs shall be registered.
REQ-019 Transition IDLE->REQ: taken when req is non-zero; grant goes to the first set bit searched upward from rr_ptr, wrapping modulo N_REQ; request2s=1 from the next cycle.
REQ-020 Transition REQ->WAIT: taken when ack=1; in the next cycle request2s=0, notice=1, and the counter clears to 0.
REQ-021 WAIT behaviour: the counter increments each cycle; on count==DELAY_CYCLES-1 the next state is SEND, so notice is high for exactly DELAY_CYCLES cycles.
REQ-022 Entry into SEND: notice=0, valid=1, and data latches the owner's req_data slice, which is captured once and held for the whole of SEND.
REQ-023 Transition SEND->IDLE: taken when ack=0; in the next cycle valid=0, data=0, grant=0, done[owner]=1 for one cycle, and rr_ptr=owner+1 mod N_REQ.
REQ-024 Timeout: the counter clears on entry to REQ and SEND; if it reaches TIMEOUT_CYCLES-1 without the awaited ack edge, the block returns to IDLE and clears all link outputs and grant.
REQ-025 On a timeout abort: timeout_err pulses for one cycle, no done pulse is issued, and rr_ptr advances past the owner.
REQ-026 ack is ignored in IDLE and WAIT.
REQ-027 A change of req or req_data by the owner after grant shall not affect the transfer in progress.
REQ-028 New requests arriving while busy are not lost: they are serviced in round-robin order after return to IDLE.
REQ-029 Minimum gap between transfers is one IDLE cycle.
REQ-030 At most one bit of grant and of done shall be high at any time.
REQ-031 Counter width: 28 bits, compared at full width with no wrap-around.

Reset
REQ-032 While rst_n=0 at a clock edge, all of the following shall reset: state=IDLE, rr_ptr=0, counter=0, ack synchronizer=0.
REQ-033 Outputs in reset: request2s=0, notice=0, data=0, valid=0, grant=0, done=0, timeout_err=0, busy=0.
REQ-034 Reset asserted mid-transfer shall abort it with no done or timeout_err pulse.

Verification (DELAY_CYCLES=4, TIMEOUT_CYCLES=16, N_REQ=4)
REQ-035 Basic transfer: req=0001, req_data[2:0]=3'd5, ack rises 3 cycles after request2s and falls 2 cycles after valid. Required: request2s, then notice for exactly 4 cycles, then valid=1 with data=5, then done[0] pulse, grant back to 0.
REQ-036 Round robin: req=1111 held through four transfers. Required: grant sequence 0001, 0010, 0100, 1000, then 0001 again.
REQ-037 Request timeout: req=0100 with ack held at 0. Required: request2s high for 16 cycles, then a timeout_err pulse, no done, and the next grant search starts at bit 3.
REQ-038 Send timeout: ack held at 1 after valid rises. Required: valid drops after 16 cycles, timeout_err pulses, data=0.
REQ-039 Reset mid-transfer: rst_n=0 during WAIT. Required: all outputs 0 on the next edge; after release, req=0010 is granted 0010 because rr_ptr=0.
REQ-040 Stable payload: the owner's req_data changes and ack glitches high during WAIT. Required: data equals the value latched at SEND entry, and the state timing is unchanged.

Source files
------------

// File: rtl/c2c_link_arbiter.sv
// Round-robin arbiter that lends one chip-to-chip master link to N_REQ local requesters
// and runs the request / notice / send handshake against the slave's ack.
module c2c_link_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DELAY_CYCLES   = 100000000,
  parameter int TIMEOUT_CYCLES = 200000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] req_data,
  input  logic               ack,
  output logic               request2s,
  output logic               notice,
  output logic [2:0]         data,
  output logic               valid,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic               timeout_err,
  output logic               busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [27:0] DELAY_LAST = 28'(DELAY_CYCLES - 1);
  localparam logic [27:0] TMO_LAST   = 28'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, SEND} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [27:0]        cnt_q, cnt_d;
  logic               ack_meta_q, ack_sync_q;
  logic               request2s_q, request2s_d;
  logic               notice_q, notice_d;
  logic [2:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               tmo_q, tmo_d;
  logic               busy_q, busy_d;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   next_ptr;
  logic [2:0]         owner_data;
  int                 j;

  // First requester at or above rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!pick_vld && req[IDX_W'(j)]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == IDX_W'(i)) owner_data = req_data[3*i +: 3];
    end
  end

  assign next_ptr = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    request2s_d = request2s_q;
    notice_d    = notice_q;
    data_d      = data_q;
    valid_d     = valid_q;
    grant_d     = grant_q;
    done_d      = '0;
    tmo_d       = 1'b0;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d     = REQ;
          owner_d     = pick_idx;
          grant_d     = N_REQ'(1) << pick_idx;
          request2s_d = 1'b1;
          cnt_d       = '0;
          busy_d      = 1'b1;
        end
      end
      REQ: begin
        if (ack_sync_q) begin
          state_d     = WAIT;
          request2s_d = 1'b0;
          notice_d    = 1'b1;
          cnt_d       = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d     = IDLE;
          request2s_d = 1'b0;
          grant_d     = '0;
          tmo_d       = 1'b1;
          busy_d      = 1'b0;
          rr_ptr_d    = next_ptr;
        end else begin
          cnt_d = cnt_q + 28'd1;
        end
      end
      WAIT: begin
        // ack is deliberately not looked at while the notice delay runs.
        if (cnt_q == DELAY_LAST) begin
          state_d  = SEND;
          notice_d = 1'b0;
          valid_d  = 1'b1;
          data_d   = owner_data;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 28'd1;
        end
      end
      SEND: begin
        if (!ack_sync_q || cnt_q == TMO_LAST) begin
          state_d  = IDLE;
          valid_d  = 1'b0;
          data_d   = '0;
          grant_d  = '0;
          busy_d   = 1'b0;
          rr_ptr_d = next_ptr;
          if (!ack_sync_q) done_d = grant_q;
          else             tmo_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 28'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      ack_meta_q  <= 1'b0;
      ack_sync_q  <= 1'b0;
      request2s_q <= 1'b0;
      notice_q    <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      grant_q     <= '0;
      done_q      <= '0;
      tmo_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      ack_meta_q  <= ack;
      ack_sync_q  <= ack_meta_q;
      request2s_q <= request2s_d;
      notice_q    <= notice_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
    end
  end

  assign request2s   = request2s_q;
  assign notice      = notice_q;
  assign data        = data_q;
  assign valid       = valid_q;
  assign grant       = grant_q;
  assign done        = done_q;
  assign timeout_err = tmo_q;
  assign busy        = busy_q;

endmodule
